// File: rtl/col_addr_skid_buf.sv
// col_addr_skid_buf: two-entry skid buffer for column addresses with per-pipeline-cycle accept limit and drain error flag
module col_addr_skid_buf #(
    parameter int COL_ADDR_W        = 8,
    parameter int MAX_ALLOC_SEQ_NUM = 2,
    parameter int CNT_W             = $clog2(MAX_ALLOC_SEQ_NUM + 1)
) (
    input  logic                  sys_clk,
    input  logic                  rstn,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [COL_ADDR_W-1:0] col_addr_i,
    input  logic                  pipeCycle_begin_i,
    input  logic                  isColAddr_skid_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [COL_ADDR_W-1:0] col_addr_o,
    output logic                  skid_occupied_o,
    output logic [CNT_W-1:0]      alloc_seq_cnt_o,
    output logic                  drain_err_o
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ALLOC_SEQ_NUM);
    logic [1:0]            r_state;
    logic [COL_ADDR_W-1:0] r_main;
    logic [COL_ADDR_W-1:0] r_skid;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_err;
    logic                  w_acc;
    logic                  w_fire;
    assign in_ready_o      = (r_state != FULL) && (r_cnt < MAX_CNT);
    assign out_valid_o     = (r_state != EMPTY) && !isColAddr_skid_i;
    assign w_acc           = in_valid_i && in_ready_o;
    assign w_fire          = out_valid_o && out_ready_i;
    assign col_addr_o      = r_main;
    assign skid_occupied_o = (r_state == FULL);
    assign alloc_seq_cnt_o = r_cnt;
    assign drain_err_o     = r_err;
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: if (w_acc) begin
                    r_main  <= col_addr_i;
                    r_state <= BUSY;
                end
                BUSY: if (w_acc && w_fire) begin
                    r_main <= col_addr_i;
                end else if (w_acc) begin
                    r_skid  <= col_addr_i;
                    r_state <= FULL;
                end else if (w_fire) begin
                    r_state <= EMPTY;
                end
                FULL: if (w_fire) begin
                    r_main  <= r_skid;
                    r_state <= BUSY;
                end
                default: r_state <= EMPTY;
            endcase
            // a new pipeline cycle restarts the count, keeping any same-cycle accept
            r_cnt <= pipeCycle_begin_i ? CNT_W'(w_acc) : r_cnt + CNT_W'(w_acc);
            if (pipeCycle_begin_i && r_state == FULL) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_col_addr_skid_buf.sv
// tb_col_addr_skid_buf: scenario tasks against a queue-based reference model of the skid buffer
module tb_col_addr_skid_buf;
    logic       sys_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [7:0] col_addr_i = '0;
    logic       pipeCycle_begin_i = 1'b0;
    logic       isColAddr_skid_i = 1'b0;
    logic       out_valid_o;
    logic       out_ready_i = 1'b0;
    logic [7:0] col_addr_o;
    logic       skid_occupied_o;
    logic [1:0] alloc_seq_cnt_o;
    logic       drain_err_o;
    int n_pass = 0;
    int n_tot = 0;
    logic [7:0] sb[$];
    int m_seq = 0;
    logic m_err = 1'b0;

    col_addr_skid_buf #(.COL_ADDR_W(8), .MAX_ALLOC_SEQ_NUM(2)) dut (
        .sys_clk(sys_clk), .rstn(rstn), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .col_addr_i(col_addr_i), .pipeCycle_begin_i(pipeCycle_begin_i),
        .isColAddr_skid_i(isColAddr_skid_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .col_addr_o(col_addr_o), .skid_occupied_o(skid_occupied_o),
        .alloc_seq_cnt_o(alloc_seq_cnt_o), .drain_err_o(drain_err_o)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic e_ready();
        return sb.size() < 2 && m_seq < 2;
    endfunction

    function automatic logic e_valid();
        return sb.size() > 0 && !isColAddr_skid_i;
    endfunction

    task automatic drive(input logic v, input logic [7:0] a, input logic rdy, input logic sk, input logic pcb);
        @(negedge sys_clk);
        in_valid_i = v;
        col_addr_i = a;
        out_ready_i = rdy;
        isColAddr_skid_i = sk;
        pipeCycle_begin_i = pcb;
        #1;
    endtask

    task automatic adv();
        logic acc, fire;
        acc = in_valid_i && e_ready();
        fire = e_valid() && out_ready_i;
        if (pipeCycle_begin_i && sb.size() == 2) m_err = 1'b1;
        if (fire) void'(sb.pop_front());
        if (acc) sb.push_back(col_addr_i);
        m_seq = pipeCycle_begin_i ? int'(acc) : m_seq + int'(acc);
        @(posedge sys_clk);
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        rstn = 1'b0;
        @(posedge sys_clk);
        #1;
        n_tot++; if (out_valid_o !== 1'b0) $display("FAIL rst_valid got %0b want 0", out_valid_o); else n_pass++;
        n_tot++; if (col_addr_o !== 8'h00) $display("FAIL rst_addr got %h want 00", col_addr_o); else n_pass++;
        n_tot++; if (skid_occupied_o !== 1'b0) $display("FAIL rst_skid got %0b want 0", skid_occupied_o); else n_pass++;
        n_tot++; if (alloc_seq_cnt_o !== 2'd0) $display("FAIL rst_cnt got %0d want 0", alloc_seq_cnt_o); else n_pass++;
        n_tot++; if (drain_err_o !== 1'b0) $display("FAIL rst_err got %0b want 0", drain_err_o); else n_pass++;
        @(negedge sys_clk);
        rstn = 1'b1;
        #1;
        n_tot++; if (in_ready_o !== 1'b1) $display("FAIL rst_ready got %0b want 1", in_ready_o); else n_pass++;
    endtask

    task automatic test_pass_through();
        drive(1, 8'h11, 1, 0, 0);
        n_tot++; if (out_valid_o !== 1'b0) $display("FAIL pt_valid0 got %0b want 0", out_valid_o); else n_pass++;
        adv();
        drive(0, 8'h00, 1, 0, 0);
        n_tot++; if (out_valid_o !== 1'b1) $display("FAIL pt_valid1 got %0b want 1", out_valid_o); else n_pass++;
        n_tot++; if (col_addr_o !== sb[0]) $display("FAIL pt_addr got %h want %h", col_addr_o, sb[0]); else n_pass++;
        n_tot++; if (alloc_seq_cnt_o !== 2'd1) $display("FAIL pt_cnt got %0d want 1", alloc_seq_cnt_o); else n_pass++;
        adv();
        drive(0, 8'h00, 1, 0, 1);
        n_tot++; if (out_valid_o !== 1'b0) $display("FAIL pt_empty got %0b want 0", out_valid_o); else n_pass++;
        adv();
    endtask

    task automatic test_skid_fill();
        drive(1, 8'h21, 0, 0, 0);
        adv();
        drive(1, 8'h22, 0, 0, 0);
        n_tot++; if (in_ready_o !== 1'b1) $display("FAIL sf_ready1 got %0b want 1", in_ready_o); else n_pass++;
        n_tot++; if (col_addr_o !== 8'h21) $display("FAIL sf_addr1 got %h want 21", col_addr_o); else n_pass++;
        adv();
        drive(0, 8'h00, 0, 0, 0);
        n_tot++; if (skid_occupied_o !== 1'b1) $display("FAIL sf_skid got %0b want 1", skid_occupied_o); else n_pass++;
        n_tot++; if (in_ready_o !== 1'b0) $display("FAIL sf_ready_full got %0b want 0", in_ready_o); else n_pass++;
        n_tot++; if (alloc_seq_cnt_o !== 2'd2) $display("FAIL sf_cnt got %0d want 2", alloc_seq_cnt_o); else n_pass++;
        adv();
        drive(0, 8'h00, 1, 0, 0);
        n_tot++; if (out_valid_o !== 1'b1 || col_addr_o !== sb[0]) $display("FAIL sf_out1 got %0b/%h want 1/%h", out_valid_o, col_addr_o, sb[0]); else n_pass++;
        adv();
        drive(0, 8'h00, 1, 0, 1);
        n_tot++; if (out_valid_o !== 1'b1 || col_addr_o !== 8'h22) $display("FAIL sf_out2 got %0b/%h want 1/22", out_valid_o, col_addr_o); else n_pass++;
        n_tot++; if (skid_occupied_o !== 1'b0) $display("FAIL sf_skid_clr got %0b want 0", skid_occupied_o); else n_pass++;
        adv();
    endtask

    task automatic test_skid_hold();
        drive(1, 8'h31, 1, 0, 0);
        adv();
        drive(1, 8'h32, 1, 1, 0);
        n_tot++; if (out_valid_o !== 1'b0) $display("FAIL sh_valid got %0b want 0", out_valid_o); else n_pass++;
        n_tot++; if (in_ready_o !== 1'b1) $display("FAIL sh_ready got %0b want 1", in_ready_o); else n_pass++;
        adv();
        drive(0, 8'h00, 1, 0, 0);
        n_tot++; if (skid_occupied_o !== 1'b1) $display("FAIL sh_skid got %0b want 1", skid_occupied_o); else n_pass++;
        n_tot++; if (out_valid_o !== 1'b1 || col_addr_o !== 8'h31) $display("FAIL sh_out1 got %0b/%h want 1/31", out_valid_o, col_addr_o); else n_pass++;
        adv();
        drive(0, 8'h00, 1, 0, 1);
        n_tot++; if (out_valid_o !== 1'b1 || col_addr_o !== 8'h32) $display("FAIL sh_out2 got %0b/%h want 1/32", out_valid_o, col_addr_o); else n_pass++;
        adv();
    endtask

    task automatic test_seq_limit();
        drive(1, 8'h41, 1, 0, 0);
        adv();
        drive(1, 8'h42, 1, 0, 0);
        n_tot++; if (col_addr_o !== 8'h41) $display("FAIL sl_addr got %h want 41", col_addr_o); else n_pass++;
        adv();
        drive(1, 8'h43, 1, 0, 0);
        n_tot++; if (alloc_seq_cnt_o !== 2'd2) $display("FAIL sl_cnt got %0d want 2", alloc_seq_cnt_o); else n_pass++;
        n_tot++; if (in_ready_o !== 1'b0) $display("FAIL sl_ready got %0b want 0", in_ready_o); else n_pass++;
        n_tot++; if (col_addr_o !== 8'h42) $display("FAIL sl_addr2 got %h want 42", col_addr_o); else n_pass++;
        adv();
        drive(1, 8'h44, 1, 0, 1);
        n_tot++; if (in_ready_o !== 1'b0) $display("FAIL sl_ready_pcb got %0b want 0", in_ready_o); else n_pass++;
        adv();
        drive(0, 8'h00, 1, 0, 0);
        n_tot++; if (alloc_seq_cnt_o !== 2'd0) $display("FAIL sl_cnt_clr got %0d want 0", alloc_seq_cnt_o); else n_pass++;
        n_tot++; if (in_ready_o !== 1'b1) $display("FAIL sl_ready_resume got %0b want 1", in_ready_o); else n_pass++;
        n_tot++; if (out_valid_o !== 1'b0) $display("FAIL sl_no_dup got %0b want 0", out_valid_o); else n_pass++;
        adv();
    endtask

    task automatic test_drain_err();
        drive(1, 8'h51, 0, 0, 0);
        adv();
        drive(1, 8'h52, 0, 0, 0);
        adv();
        drive(0, 8'h00, 0, 0, 1);
        n_tot++; if (drain_err_o !== 1'b0) $display("FAIL de_pre got %0b want 0", drain_err_o); else n_pass++;
        adv();
        drive(0, 8'h00, 1, 0, 0);
        n_tot++; if (drain_err_o !== 1'b1) $display("FAIL de_set got %0b want 1", drain_err_o); else n_pass++;
        n_tot++; if (col_addr_o !== 8'h51) $display("FAIL de_addr1 got %h want 51", col_addr_o); else n_pass++;
        adv();
        drive(0, 8'h00, 1, 0, 0);
        n_tot++; if (col_addr_o !== 8'h52) $display("FAIL de_addr2 got %h want 52", col_addr_o); else n_pass++;
        adv();
        drive(0, 8'h00, 1, 0, 0);
        n_tot++; if (drain_err_o !== 1'b1) $display("FAIL de_sticky got %0b want 1", drain_err_o); else n_pass++;
        adv();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 4) == 0), 1'(i % 4 == 0));
            n_tot++; if (in_ready_o !== e_ready()) $display("FAIL bb_ready[%0d] got %0b want %0b", i, in_ready_o, e_ready()); else n_pass++;
            n_tot++; if (out_valid_o !== e_valid()) $display("FAIL bb_valid[%0d] got %0b want %0b", i, out_valid_o, e_valid()); else n_pass++;
            n_tot++; if (skid_occupied_o !== (sb.size() == 2)) $display("FAIL bb_skid[%0d] got %0b want %0b", i, skid_occupied_o, sb.size() == 2); else n_pass++;
            n_tot++; if (alloc_seq_cnt_o !== 2'(m_seq)) $display("FAIL bb_cnt[%0d] got %0d want %0d", i, alloc_seq_cnt_o, m_seq); else n_pass++;
            n_tot++; if (drain_err_o !== m_err) $display("FAIL bb_err[%0d] got %0b want %0b", i, drain_err_o, m_err); else n_pass++;
            if (sb.size() > 0) begin
                n_tot++; if (col_addr_o !== sb[0]) $display("FAIL bb_addr[%0d] got %h want %h", i, col_addr_o, sb[0]); else n_pass++;
            end
            adv();
        end
    endtask

    task automatic test_mid_reset();
        drive(1, 8'h61, 0, 0, 1);
        adv();
        drive(1, 8'h62, 0, 0, 0);
        adv();
        drive(0, 8'h00, 1, 0, 0);
        n_tot++; if (skid_occupied_o !== 1'b1) $display("FAIL mr_full got %0b want 1", skid_occupied_o); else n_pass++;
        rstn = 1'b0;
        @(posedge sys_clk);
        #1;
        sb.delete();
        m_seq = 0;
        m_err = 1'b0;
        n_tot++; if (out_valid_o !== 1'b0) $display("FAIL mr_valid got %0b want 0", out_valid_o); else n_pass++;
        n_tot++; if (alloc_seq_cnt_o !== 2'd0) $display("FAIL mr_cnt got %0d want 0", alloc_seq_cnt_o); else n_pass++;
        n_tot++; if (col_addr_o !== 8'h00) $display("FAIL mr_addr got %h want 00", col_addr_o); else n_pass++;
        n_tot++; if (skid_occupied_o !== 1'b0) $display("FAIL mr_skid got %0b want 0", skid_occupied_o); else n_pass++;
        n_tot++; if (drain_err_o !== 1'b0) $display("FAIL mr_err got %0b want 0", drain_err_o); else n_pass++;
        @(negedge sys_clk);
        rstn = 1'b1;
        in_valid_i = 1'b0;
        #1;
        n_tot++; if (in_ready_o !== 1'b1) $display("FAIL mr_ready got %0b want 1", in_ready_o); else n_pass++;
        n_tot++; if (out_valid_o !== 1'b0) $display("FAIL mr_nofire got %0b want 0", out_valid_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_skid_fill();
        test_skid_hold();
        test_seq_limit();
        test_drain_err();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/col_addr_skid_buf.md
COL_ADDR_SKID_BUF -- requirements
Module: col_addr_skid_buf

Interface
REQ-001 Parameter COL_ADDR_W, default 8: width of one column address.
REQ-002 Parameter MAX_ALLOC_SEQ_NUM, default 2: maximum number of accepted addresses per pipeline cycle of SCU.memShare().
REQ-003 sys_clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 in_valid_i  input  1  upstream column address is valid.
REQ-006 in_ready_o  output  1  block can accept an address this cycle.
REQ-007 col_addr_i  input  COL_ADDR_W  incoming column address.
REQ-008 pipeCycle_begin_i  input  1  first cycle of a SCU.memShare() pipeline cycle.
REQ-009 isColAddr_skid_i  input  1  skid select from the skid control generator: 1 = SKID (hold output), 0 = NOSKID.
REQ-010 out_valid_o  output  1  col_addr_o is valid.
REQ-011 out_ready_i  input  1  downstream accepts col_addr_o.
REQ-012 col_addr_o  output  COL_ADDR_W  column address to shared-memory allocation.
REQ-013 skid_occupied_o  output  1  skid register holds a valid address.
REQ-014 alloc_seq_cnt_o  output  $clog2(MAX_ALLOC_SEQ_NUM+1)  addresses accepted in current pipeline cycle.
REQ-015 drain_err_o  output  1  sticky protocol error flag.

Function
REQ-016 The block SHALL contain a main register and a skid register, with states EMPTY, BUSY (main valid) and FULL (main and skid valid).
REQ-017 The accept condition SHALL be acc = in_valid_i & in_ready_o.
REQ-018 The fire condition SHALL be fire = out_valid_o & out_ready_i.
REQ-019 out_valid_o SHALL equal (state != EMPTY) & !isColAddr_skid_i; SKID therefore withholds the output for that cycle.
REQ-020 col_addr_o SHALL always equal the main register.
REQ-021 skid_occupied_o SHALL be 1 exactly in FULL.
REQ-022 in_ready_o SHALL equal (state != FULL) & (alloc_seq_cnt_o < MAX_ALLOC_SEQ_NUM); it is combinational with no dependency on in_valid_i.
REQ-023 In EMPTY, the block SHALL load main from col_addr_i and go to BUSY on acc; otherwise it stays EMPTY.
REQ-024 In BUSY, the block SHALL transition as follows:
- acc & fire: main <= col_addr_i, stay BUSY.
- acc & !fire: skid <= col_addr_i, go to FULL.
- !acc & fire: go to EMPTY.
- Otherwise: hold.
REQ-025 In FULL, the block SHALL set main <= skid and go to BUSY on fire; otherwise it holds, and no accept is possible.
REQ-026 Latency SHALL be 1 cycle from acceptance to out_valid_o in EMPTY, and addresses SHALL leave in acceptance order with no loss or duplication.
REQ-027 The alloc_seq_cnt_o counter SHALL operate as follows:
- Increment by 1 on acc.
- Cleared to 0 on pipeCycle_begin_i, or to 1 if acc occurs in the same cycle.
- Never exceeds MAX_ALLOC_SEQ_NUM.
REQ-028 When alloc_seq_cnt_o = MAX_ALLOC_SEQ_NUM, in_ready_o SHALL be 0 until the cycle in which pipeCycle_begin_i is asserted; in_ready_o is still 0 during that cycle, and acceptance resumes the following cycle.
REQ-029 drain_err_o SHALL be set to 1 when pipeCycle_begin_i = 1 while state = FULL, and remain 1 until reset.
REQ-030 Register contents outside valid states SHALL be don't-care for outputs but SHALL NOT be X after reset.

Reset
REQ-031 On rstn = 0 at a clock edge, the block SHALL set state = EMPTY, main = 0, skid = 0, counter = 0 and drain_err_o = 0, regardless of any transfer in progress.
REQ-032 During and right after reset, the outputs SHALL be out_valid_o = 0, skid_occupied_o = 0 and col_addr_o = 0; in_ready_o = 1 from the first cycle after reset release.
REQ-033 Reset asserted mid-operation SHALL discard buffered addresses, and no fire SHALL occur in the cycle following reset.

Verification
REQ-034 Pass-through: with out_ready_i = 1 and NOSKID, accept 0x11 in cycle 0 -> col_addr_o = 0x11 with out_valid_o = 1 in cycle 1.
REQ-035 Skid fill: accept 0x21 then 0x22 with out_ready_i = 0 -> FULL, skid_occupied_o = 1, in_ready_o = 0; raise out_ready_i -> outputs 0x21 then 0x22 in consecutive cycles.
REQ-036 SKID hold: BUSY holding 0x31, isColAddr_skid_i = 1, out_ready_i = 1, accept 0x32 -> out_valid_o = 0, 0x32 captured in skid; next cycle NOSKID -> 0x31 then 0x32 out.
REQ-037 Sequence limit (MAX = 2): two accepts after pipeCycle_begin_i -> alloc_seq_cnt_o = 2, in_ready_o = 0; pulse pipeCycle_begin_i -> counter 0 and in_ready_o = 1 next cycle.
REQ-038 Drain error: pipeCycle_begin_i = 1 while FULL -> drain_err_o = 1 next cycle and stays 1 until rstn = 0.
REQ-039 Mid-op reset: rstn = 0 while FULL -> next cycle state EMPTY, out_valid_o = 0, alloc_seq_cnt_o = 0, col_addr_o = 0.
